stage_buf: RTL

STAGE_BUF -- requirements
Module: stage_buf

---
 rtl/stage_buf_pkg.sv | 29 ++
 rtl/stage_buf_sat_cnt8.sv | 35 +++
 rtl/stage_buf.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/stage_buf_pkg.sv
// Shared definitions for the two-entry staging buffer: state encoding,
// default geometry and a small state-to-occupancy decode helper.
package stage_buf_pkg;

  // Default width of one channel word and number of channels per entry.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_CH   = 2;

  // Buffer fill states; the encoding is fixed so that waveforms and any
  // external checkers can rely on it.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Number of entries held in a given state.
  function automatic logic [1:0] occupancy_of(input state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : stage_buf_pkg

// File: rtl/stage_buf_sat_cnt8.sv
// Eight-bit up-counter that adds a 0..3 increment every cycle and sticks
// at 255 instead of wrapping. Used to count entries discarded by flush.
module sat_cnt8 (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [8:0] sum_s;

  // Next count: widen by one bit so an overflow is visible, then clamp.
  always_comb begin
    sum_s = {1'b0, cnt_q} + {7'd0, inc};
    if (sum_s[8]) begin
      cnt_d = 8'hFF;
    end else begin
      cnt_d = sum_s[7:0];
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_cnt8

// File: rtl/stage_buf.sv
// Two-entry staging buffer (head register plus skid register) with a
// ready/valid handshake on both sides, synchronous flush and a saturating
// count of flushed entries. in_ready never depends on out_ready, so the
// buffer breaks the combinational ready path between its neighbours.
module stage_buf
  import stage_buf_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                N_CH      = DEF_N_CH,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [1:0]             occupancy,
  output logic [7:0]             drop_cnt
);

  localparam int ENTRY_W = N_CH * DATA_W;

  // Every channel word of both data registers starts at RESET_VAL.
  localparam logic [ENTRY_W-1:0] ENTRY_RESET = {N_CH{RESET_VAL}};

  state_e               state_q;
  state_e               state_d;
  logic                 rdy_en_q;
  logic                 rdy_en_d;
  logic [ENTRY_W-1:0]   main_q;
  logic [ENTRY_W-1:0]   main_d;
  logic [ENTRY_W-1:0]   skid_q;
  logic [ENTRY_W-1:0]   skid_d;
  logic                 push_s;
  logic                 pop_s;
  logic [1:0]           drop_inc_s;

  // Output decode: everything here comes from registers, except that flush
  // masks in_ready so nothing is accepted in the cycle that empties us.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    occupancy = occupancy_of(state_q);
    case (state_q)
      EMPTY: begin
        in_ready  = rdy_en_q & ~flush;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = rdy_en_q & ~flush;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers; a pop coinciding with flush is ignored.
  always_comb begin
    push_s = in_valid & in_ready;
    pop_s  = out_valid & out_ready & ~flush;
  end

  // Next state and data: the head register always holds the oldest entry,
  // the skid register only ever holds the second one.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers keep their contents; they are simply marked invalid.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d = ONE;
            main_d  = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (push_s && !pop_s) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop_s && !push_s) begin
            state_d = EMPTY;
          end else if (push_s && pop_s) begin
            state_d = ONE;
            main_d  = in_data;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            state_d = ONE;
            main_d  = skid_q;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Ready enable goes high on the first clock after reset releases and
  // stays there, keeping in_ready low throughout reset.
  always_comb begin
    rdy_en_d = 1'b1;
  end

  // State register and ready-enable flop.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= EMPTY;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Head and skid data registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      main_q <= ENTRY_RESET;
      skid_q <= ENTRY_RESET;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Amount discarded this cycle: the current fill level when flushing.
  always_comb begin
    if (flush) begin
      drop_inc_s = occupancy_of(state_q);
    end else begin
      drop_inc_s = 2'd0;
    end
  end

  sat_cnt8 u_drop_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .inc   (drop_inc_s),
    .cnt   (drop_cnt)
  );

  assign out_data = main_q;

endmodule : stage_buf
